// File: rtl/gray_wr_pkg.sv
// rtl/gray_wr_pkg.sv - shared constants and FSM state type for the gray word packer
package gray_wr_pkg;

  localparam int WORD_W       = 32;
  localparam int PIX_PER_WORD = 4;
  localparam int PIX_W        = WORD_W / PIX_PER_WORD;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo_sa.sv
// rtl/sync_fifo_sa.sv - show-ahead synchronous FIFO with full/empty/count
module sync_fifo_sa #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  // A pop frees a slot in the same cycle, so a push on a full FIFO is still taken
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    head    = mem[rd_ptr];
  end

  // Storage array; not reset, the consumer only looks at it when non-empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= PTR_W'(wr_ptr + 1);
      end
      if (do_pop) begin
        rd_ptr <= PTR_W'(rd_ptr + 1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= CNT_W'(count + 1);
        2'b01:   count <= CNT_W'(count - 1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gray_wr_packer.sv
// rtl/gray_wr_packer.sv - packs 4 luma pixels per word and queues word writes to memory
module gray_wr_packer
  import gray_wr_pkg::*;
#(
  parameter int               ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int               FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hav,
  input  logic              i_vav,
  input  logic [7:0]        i_y,
  output logic              o_wr_req,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  input  logic              i_wr_ack,
  output logic              o_ovf,
  output logic              o_frame_done,
  output logic              o_busy
);

  localparam int ENTRY_W = ADDR_W + WORD_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ACC_W   = WORD_W - PIX_W;

  state_e             state;
  state_e             state_nxt;
  logic               frame_start;
  logic               frame_done;

  logic               hav_q;
  logic               vav_q;
  logic [1:0]         lc;
  logic [ACC_W-1:0]   acc;
  logic [ADDR_W-1:0]  wa;

  logic               vav_rise;
  logic               vav_fall;
  logic               hav_fall;
  logic               pv;
  logic               pix_push;
  logic               flush;
  logic               push;
  logic [WORD_W-1:0]  push_word;
  logic               pop;

  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // Edge detection, pixel qualification and push selection
  always_comb begin
    vav_rise  = ~vav_q & i_vav;
    vav_fall  = vav_q & ~i_vav;
    hav_fall  = hav_q & ~i_hav;
    pv        = i_hav & i_vav & (state == ACTIVE);
    pix_push  = pv & (lc == 2'd3);
    flush     = (state == ACTIVE) & (hav_fall | vav_fall) & (lc != 2'd0);
    push      = pix_push | flush;
    push_word = pix_push ? {i_y, acc} : {{PIX_W{1'b0}}, acc};
    pop       = o_wr_req & i_wr_ack;
  end

  // FSM next-state and frame-level outputs
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (vav_rise) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (vav_fall) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Packing datapath; vav_q resets high so a frame already in progress at reset is skipped
  always_ff @(posedge clk) begin
    if (rst) begin
      hav_q <= 1'b0;
      vav_q <= 1'b1;
      lc    <= 2'd0;
      acc   <= '0;
      wa    <= BASE_ADDR;
      o_ovf <= 1'b0;
    end else begin
      hav_q <= i_hav;
      vav_q <= i_vav;
      if (frame_start) begin
        lc  <= 2'd0;
        acc <= '0;
        wa  <= BASE_ADDR;
      end else if (push) begin
        lc  <= 2'd0;
        acc <= '0;
        wa  <= wa + ADDR_W'(1);
      end else if (pv) begin
        case (lc)
          2'd0:    acc[7:0]   <= i_y;
          2'd1:    acc[15:8]  <= i_y;
          default: acc[23:16] <= i_y;
        endcase
        lc <= lc + 2'd1;
      end
      if (push & fifo_full & ~pop) begin
        o_ovf <= 1'b1;
      end
    end
  end

  sync_fifo_sa #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({wa, push_word}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Write port; head fields are forced to zero while nothing is queued
  always_comb begin
    o_wr_req     = (fifo_count != '0);
    o_wr_addr    = fifo_empty ? '0 : fifo_head[WORD_W +: ADDR_W];
    o_wr_data    = fifo_empty ? '0 : fifo_head[WORD_W-1:0];
    o_frame_done = frame_done;
    o_busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_gray_wr_packer.sv
// tb/tb_gray_wr_packer.sv - directed self-checking bench for gray_wr_packer
module tb_gray_wr_packer;

  localparam int          ADDR_W = 24;
  localparam logic [23:0] BASE   = 24'h000100;
  localparam int          DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_hav;
  logic              i_vav;
  logic [7:0]        i_y;
  logic              i_wr_ack;
  logic              o_wr_req;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [31:0]       o_wr_data;
  logic              o_ovf;
  logic              o_frame_done;
  logic              o_busy;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int done_cnt = 0;

  gray_wr_packer #(
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_hav        (i_hav),
    .i_vav        (i_vav),
    .i_y          (i_y),
    .o_wr_req     (o_wr_req),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .i_wr_ack     (i_wr_ack),
    .o_ovf        (o_ovf),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  // Count cycles with frame_done high, sampled mid-cycle
  always @(negedge clk) begin
    if (o_frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] y);
    i_hav = 1'b1;
    i_y   = y;
    tick();
  endtask

  task automatic line_end;
    i_hav = 1'b0;
    i_y   = 8'h00;
    tick();
  endtask

  task automatic frame_begin;
    i_vav = 1'b1;
    tick();
  endtask

  task automatic frame_end;
    i_hav = 1'b0;
    i_vav = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, o_busy, 1'b0);
  endtask

  function automatic logic [31:0] w4(input logic [7:0] b);
    logic [7:0] b1, b2, b3;
    b1 = b + 8'd1;
    b2 = b + 8'd2;
    b3 = b + 8'd3;
    return {b3, b2, b1, b};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},  o_wr_req,     1'b0);
    chk({tag, "_addr"}, o_wr_addr,    24'h0);
    chk({tag, "_data"}, o_wr_data,    32'h0);
    chk({tag, "_ovf"},  o_ovf,        1'b0);
    chk({tag, "_done"}, o_frame_done, 1'b0);
    chk({tag, "_busy"}, o_busy,       1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_hav = 1'b0; i_vav = 1'b0; i_y = 8'h00; i_wr_ack = 1'b0;
    tick(); tick(); tick();
    chk_reset_outputs("rst0");
    rst = 1'b0;
    tick();

    // 8-pixel line, ack held high
    i_wr_ack = 1'b1;
    frame_begin();
    for (int i = 1; i <= 4; i++) pix(8'(i));
    chk("t1_req0",  o_wr_req,  1'b1);
    chk("t1_addr0", o_wr_addr, BASE);
    chk("t1_data0", o_wr_data, 32'h04030201);
    pix(8'h05);
    chk("t1_popped", o_wr_req, 1'b0);
    for (int i = 6; i <= 8; i++) pix(8'(i));
    chk("t1_req1",  o_wr_req,  1'b1);
    chk("t1_addr1", o_wr_addr, BASE + 24'd1);
    chk("t1_data1", o_wr_data, 32'h08070605);
    line_end();
    chk("t1_empty", o_wr_req, 1'b0);
    frame_end();
    wait_idle("t1_idle");
    chk("t1_done", done_cnt, 1);

    // 6-pixel line, partial word flushed on hav fall
    frame_begin();
    for (int i = 0; i < 4; i++) pix(8'(8'h11 + i));
    chk("t2_addr0", o_wr_addr, BASE);
    chk("t2_data0", o_wr_data, 32'h14131211);
    pix(8'h15);
    pix(8'h16);
    chk("t2_noflush_yet", o_wr_req, 1'b0);
    line_end();
    chk("t2_req1",  o_wr_req,  1'b1);
    chk("t2_addr1", o_wr_addr, BASE + 24'd1);
    chk("t2_data1", o_wr_data, 32'h00001615);
    frame_end();
    wait_idle("t2_idle");
    chk("t2_done", done_cnt, 2);

    // 64-pixel line with ack low: overflow after 8 words
    i_wr_ack = 1'b0;
    frame_begin();
    for (int i = 0; i < 32; i++) pix(8'(i));
    chk("t3_ovf_at_full", o_ovf, 1'b0);
    for (int i = 32; i < 64; i++) begin
      pix(8'(i));
      if (i == 35) chk("t3_ovf_first_drop", o_ovf, 1'b1);
    end
    chk("t3_req",  o_wr_req,  1'b1);
    chk("t3_addr", o_wr_addr, BASE);
    chk("t3_data", o_wr_data, 32'h03020100);
    line_end();
    frame_end();
    chk("t3_busy_drain", o_busy, 1'b1);
    chk("t3_no_done",    o_frame_done, 1'b0);
    i_wr_ack = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("t3_drain_req",  o_wr_req,  1'b1);
      chk("t3_drain_addr", o_wr_addr, 64'(BASE) + 64'(j));
      chk("t3_drain_data", o_wr_data, w4(8'(4 * j)));
      tick();
    end
    chk("t3_drained", o_wr_req, 1'b0);
    wait_idle("t3_idle");
    chk("t3_done", done_cnt, 3);
    chk("t3_ovf_sticky", o_ovf, 1'b1);

    rst = 1'b1;
    tick();
    chk("rst1_ovf", o_ovf, 1'b0);
    rst = 1'b0;
    i_wr_ack = 1'b0;
    tick();

    // Full FIFO with push and pop in the same cycle
    frame_begin();
    for (int i = 0; i < 32; i++) pix(8'(8'h40 + i));
    chk("t4_full_req",  o_wr_req,  1'b1);
    chk("t4_full_addr", o_wr_addr, BASE);
    for (int i = 32; i < 35; i++) pix(8'(8'h40 + i));
    i_wr_ack = 1'b1;
    pix(8'h63);
    i_wr_ack = 1'b0;
    chk("t4_ovf",  o_ovf,     1'b0);
    chk("t4_addr", o_wr_addr, BASE + 24'd1);
    chk("t4_data", o_wr_data, w4(8'h44));
    line_end();
    frame_end();
    i_wr_ack = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("t4_drain_req",  o_wr_req,  1'b1);
      chk("t4_drain_addr", o_wr_addr, 64'(BASE) + 64'(j + 1));
      chk("t4_drain_data", o_wr_data, w4(8'(8'h44 + 4 * j)));
      tick();
    end
    chk("t4_drained", o_wr_req, 1'b0);
    wait_idle("t4_idle");
    chk("t4_done", done_cnt, 4);

    // Two consecutive 4-pixel frames both start at BASE
    for (int f = 0; f < 2; f++) begin
      frame_begin();
      for (int i = 0; i < 4; i++) pix(8'(8'h21 + 4 * f + i));
      chk("t5_req",  o_wr_req,  1'b1);
      chk("t5_addr", o_wr_addr, BASE);
      chk("t5_data", o_wr_data, w4(8'(8'h21 + 4 * f)));
      line_end();
      frame_end();
      wait_idle("t5_idle");
      chk("t5_done", done_cnt, 5 + f);
    end

    // Reset mid-line with three words queued
    i_wr_ack = 1'b0;
    frame_begin();
    for (int i = 0; i < 14; i++) pix(8'(8'h80 + i));
    chk("t6_queued", o_wr_req, 1'b1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("t6_rst");
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pix(8'h90);
      chk("t6_hold_req",  o_wr_req, 1'b0);
      chk("t6_hold_busy", o_busy,   1'b0);
    end
    frame_end();
    i_wr_ack = 1'b1;
    frame_begin();
    for (int i = 0; i < 4; i++) pix(8'(8'hA0 + i));
    chk("t6_req",  o_wr_req,  1'b1);
    chk("t6_addr", o_wr_addr, BASE);
    chk("t6_data", o_wr_data, 32'hA3A2A1A0);
    line_end();
    frame_end();
    wait_idle("t6_idle");
    chk("t6_done", done_cnt, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/gray_wr_packer.md
# gray_wr_packer

Downstream of the grayscale converter: takes the 8-bit luma stream with its `hav`/`vav` qualifiers, packs four consecutive active pixels into one 32-bit word, and issues word writes toward the memory controller through a valid/ack interface. A small show-ahead FIFO absorbs controller back-pressure. Word addresses restart at `BASE_ADDR` on every frame start.

## Interface
- `ADDR_W`, 24: word-address width.
- `BASE_ADDR`, 0: word address of the first word of every frame.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.

- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `i_hav`  in  1  line active.
- `i_vav`  in  1  frame active.
- `i_y`  in  8  gray pixel; valid when `i_hav & i_vav`.
- `o_wr_req`  out  1  write request (FIFO non-empty).
- `o_wr_addr`  out  ADDR_W  word address of the FIFO head.
- `o_wr_data`  out  32  data of the FIFO head.
- `i_wr_ack`  in  1  controller accepts the head this cycle.
- `o_ovf`  out  1  sticky: a word was dropped on a full FIFO.
- `o_frame_done`  out  1  one-cycle pulse: frame fully drained.
- `o_busy`  out  1  state ≠ IDLE.

## Operation
- Pixel valid `pv = i_hav & i_vav & (state==ACTIVE)`. Registered `hav_q`, `vav_q` hold the previous cycle's inputs.
- Packing: lane counter `lc` (2 bit). Byte lanes are little-endian: the first pixel goes to `[7:0]`. On `pv` with `lc==3`, push `{i_y, acc[23:0]}`; otherwise write lane `lc`. `lc` increments mod 4.
- Line-end flush: `hav_q & ~i_hav` with `lc≠0` pushes `acc` with unused lanes zero, then `lc←0`. `acc` is zeroed after every push.
- Address counter `wa`: set to `BASE_ADDR` on frame start; increments on every push attempt, including dropped ones, so frame geometry is preserved. Wraps mod 2^ADDR_W.
- FIFO entry is `{wa, data}`. Pop when `o_wr_req & i_wr_ack`. A push is accepted if `count<FIFO_DEPTH` or a pop occurs in the same cycle. Otherwise the word is dropped and `o_ovf←1`. `o_ovf` is cleared only by `rst`.
- FSM:
  - IDLE: on `~vav_q & i_vav` (rising edge), go to ACTIVE, `wa←BASE_ADDR`, `lc←0`.
  - ACTIVE: pack. On `vav_q & ~i_vav`, perform any pending flush (as line-end flush), then go to DRAIN.
  - DRAIN: when FIFO is empty, pulse `o_frame_done` for 1 cycle and go to IDLE.
  - A `vav` rise during DRAIN is ignored. Pixels of that frame are not packed.
- If `i_vav` is already high when `rst` deasserts, it is ignored until it falls and rises again.

## Timing
- Reset values: `o_wr_req=0`, `o_wr_addr=0`, `o_wr_data=0`, `o_ovf=0`, `o_frame_done=0`, `o_busy=0`. FIFO is emptied and the FSM is in IDLE.
- No input register. The 4th pixel, sampled at edge t, is pushed at edge t. `o_wr_req=1` in the cycle after edge t, with head addr/data valid in that same cycle.
- Head stays stable while `o_wr_req & ~i_wr_ack`. After a pop, the next entry appears in the following cycle, giving 1 word/cycle sustained with `ack` held high.
- A flush push occurs at the edge that samples the `hav` fall.
- `o_frame_done` goes high the cycle after the FIFO becomes empty in DRAIN.
- Reset mid-frame: all in-flight words are discarded, and no further `o_wr_req` is issued until a new frame starts.

## Structure
- Package `gray_wr_pkg`: `WORD_W=32`, `PIX_PER_WORD=4`, FSM state enum `{IDLE, ACTIVE, DRAIN}`.
- Sub-module `sync_fifo_sa`: parameterised show-ahead synchronous FIFO (width, depth) with `full`, `empty`, and `count` outputs. It is reused elsewhere.

## Test plan
- One 8-pixel line `0x01..0x08`, `ack=1`: writes (BASE, `0x04030201`), (BASE+1, `0x08070605`). `o_frame_done` pulses after `vav` falls.
- 6-pixel line `0x11..0x16`: second word is `0x00001615` at BASE+1, pushed on the `hav` fall.
- `ack=0` for a 64-pixel line, depth 8: 16 words attempted, 8 held (addr BASE..BASE+7), `o_ovf=1`. After release, exactly those 8 words are written in order with no gaps.
- Full FIFO with simultaneous push and `ack`: push accepted, `o_ovf` stays 0, count unchanged.
- Two consecutive frames of 4 pixels each: both write to BASE. `o_frame_done` pulses once per frame.
- `rst` asserted mid-line with 3 words queued: all outputs return to reset values the next cycle, `o_wr_req` stays low, and the next frame starts at BASE.
